// File: rtl/plaintext_key_stream_memory_if.sv
// Host-side write port and AES-side valid/ready stream bundle for plaintext_key_stream_memory.
interface plaintext_key_stream_memory_if #(
  parameter int unsigned TEXT_WIDTH = 128,
  parameter int unsigned KEY_WIDTH  = 128,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned KSEL_WIDTH = 1
) ();
  logic                  wr_en_i;
  logic                  wr_key_i;
  logic [ADDR_WIDTH-1:0] wr_addr_i;
  logic [TEXT_WIDTH-1:0] wr_text_i;
  logic [KEY_WIDTH-1:0]  wr_keyd_i;
  logic                  wr_drop_o;
  logic                  start_i;
  logic [ADDR_WIDTH-1:0] base_addr_i;
  logic [ADDR_WIDTH:0]   count_i;
  logic [KSEL_WIDTH-1:0] key_sel_i;
  logic                  abort_i;
  logic [TEXT_WIDTH-1:0] plaintext_q;
  logic [KEY_WIDTH-1:0]  key_q;
  logic [ADDR_WIDTH-1:0] pc_o;
  logic                  valid_o;
  logic                  ready_i;
  logic                  last_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;

  modport slave (
    input  wr_en_i, wr_key_i, wr_addr_i, wr_text_i, wr_keyd_i,
    input  start_i, base_addr_i, count_i, key_sel_i, abort_i, ready_i,
    output wr_drop_o, plaintext_q, key_q, pc_o, valid_o, last_o, busy_o, done_o, err_o
  );

  modport master (
    output wr_en_i, wr_key_i, wr_addr_i, wr_text_i, wr_keyd_i,
    output start_i, base_addr_i, count_i, key_sel_i, abort_i, ready_i,
    input  wr_drop_o, plaintext_q, key_q, pc_o, valid_o, last_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/plaintext_key_stream_memory.sv
// Run-time loadable plaintext/key store that streams a wrapping run of blocks plus one key
// to the AES core over valid/ready, with done/err/drop pulses.
module plaintext_key_stream_memory #(
  parameter int unsigned TEXT_WIDTH  = 128,
  parameter int unsigned KEY_WIDTH   = 128,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned MEMORY_SIZE = 16,
  parameter int unsigned KEY_SLOTS   = 2,
  parameter int unsigned KSEL_WIDTH  = 1
) (
  input logic                          clk,
  input logic                          rst,
  plaintext_key_stream_memory_if.slave bus
);

  localparam logic [ADDR_WIDTH:0]   MemSizeW  = MEMORY_SIZE[ADDR_WIDTH:0];
  localparam logic [KSEL_WIDTH:0]   KeySlotsW = KEY_SLOTS[KSEL_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(MEMORY_SIZE - 1);

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  logic [TEXT_WIDTH-1:0] r_mem  [MEMORY_SIZE];
  logic [KEY_WIDTH-1:0]  r_keys [KEY_SLOTS];

  state_e                r_state, w_state_d;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_d;
  logic [TEXT_WIDTH-1:0] r_text, w_text_d;
  logic [KEY_WIDTH-1:0]  r_key, w_key_d;
  logic [ADDR_WIDTH:0]   r_rem, w_rem_d;
  logic                  r_err, w_err_d;
  logic                  r_drop, w_drop_d;

  logic                  w_mem_we, w_key_we;
  logic [KSEL_WIDTH-1:0] w_wr_slot;
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic                  w_start_bad;

  assign w_wr_slot   = bus.wr_addr_i[KSEL_WIDTH-1:0];
  assign w_pc_next   = (r_pc == LastAddr) ? '0 : r_pc + 1'b1;
  assign w_start_bad = ({1'b0, bus.key_sel_i} >= KeySlotsW) ||
                       ({1'b0, bus.base_addr_i} >= MemSizeW);

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_text_d  = r_text;
    w_key_d   = r_key;
    w_rem_d   = r_rem;
    w_err_d   = 1'b0;
    w_drop_d  = 1'b0;
    w_mem_we  = 1'b0;
    w_key_we  = 1'b0;

    if (bus.wr_en_i) begin
      if (r_state != StIdle) begin
        w_drop_d = 1'b1;
      end else if (bus.wr_key_i) begin
        if ({1'b0, w_wr_slot} >= KeySlotsW) w_drop_d = 1'b1;
        else                                w_key_we = 1'b1;
      end else begin
        if ({1'b0, bus.wr_addr_i} >= MemSizeW) w_drop_d = 1'b1;
        else                                   w_mem_we = 1'b1;
      end
    end

    unique case (r_state)
      StIdle: begin
        // Reads here see pre-write array contents when a write lands on the same edge.
        if (bus.start_i) begin
          if (w_start_bad) begin
            w_err_d = 1'b1;
          end else if (bus.count_i == '0) begin
            w_state_d = StDone;
          end else begin
            w_text_d  = r_mem[bus.base_addr_i];
            w_key_d   = r_keys[bus.key_sel_i];
            w_pc_d    = bus.base_addr_i;
            w_rem_d   = bus.count_i;
            w_state_d = StStream;
          end
        end
      end
      StStream: begin
        if (bus.abort_i) begin
          w_state_d = StIdle;
        end else if (bus.ready_i) begin
          if (r_rem == (ADDR_WIDTH + 1)'(1)) begin
            w_state_d = StDone;
          end else begin
            w_pc_d   = w_pc_next;
            w_text_d = r_mem[w_pc_next];
            w_rem_d  = r_rem - 1'b1;
          end
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_pc    <= '0;
      r_text  <= '0;
      r_key   <= '0;
      r_rem   <= '0;
      r_err   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_text  <= w_text_d;
      r_key   <= w_key_d;
      r_rem   <= w_rem_d;
      r_err   <= w_err_d;
      r_drop  <= w_drop_d;
    end
  end

  // Storage survives reset so a host can reset the streamer without reloading.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[bus.wr_addr_i] <= bus.wr_text_i;
    if (w_key_we) r_keys[w_wr_slot]    <= bus.wr_keyd_i;
  end

  assign bus.plaintext_q = r_text;
  assign bus.key_q       = r_key;
  assign bus.pc_o        = r_pc;
  assign bus.valid_o     = (r_state == StStream);
  assign bus.last_o      = (r_state == StStream) && (r_rem == (ADDR_WIDTH + 1)'(1));
  assign bus.busy_o      = (r_state != StIdle);
  assign bus.done_o      = (r_state == StDone);
  assign bus.err_o       = r_err;
  assign bus.wr_drop_o   = r_drop;

endmodule

// File: tb/tb_plaintext_key_stream_memory.sv
// Directed, table-driven bench for plaintext_key_stream_memory (default and 1-key/12-entry builds).
module tb_plaintext_key_stream_memory;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  plaintext_key_stream_memory_if bus ();
  plaintext_key_stream_memory_if bus2 ();

  plaintext_key_stream_memory u_dut (.clk(clk), .rst(rst), .bus(bus));
  plaintext_key_stream_memory #(.MEMORY_SIZE(12), .KEY_SLOTS(1)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] AA = {16{8'hAA}};

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic         start;
    logic [3:0]   base;
    logic [4:0]   cnt;
    logic         ksel;
    logic         ready;
    logic         abort;
    logic         valid;
    logic [3:0]   pc;
    logic         last;
    logic         busy;
    logic         done;
    logic [127:0] text;
    logic [127:0] key;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [127:0] tv(int i);
    return 128'(i + 1);
  endfunction

  function automatic vec_t mk(logic st, logic [3:0] b, logic [4:0] c, logic ks, logic rd,
                              logic ab, logic v, logic [3:0] p, logic l, logic bz, logic d,
                              logic [127:0] tx, logic [127:0] k);
    vec_t r;
    r.start = st; r.base = b; r.cnt = c; r.ksel = ks; r.ready = rd; r.abort = ab;
    r.valid = v; r.pc = p; r.last = l; r.busy = bz; r.done = d; r.text = tx; r.key = k;
    return r;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    bus.wr_en_i = 0; bus.wr_key_i = 0; bus.wr_addr_i = '0; bus.wr_text_i = '0;
    bus.wr_keyd_i = '0; bus.start_i = 0; bus.base_addr_i = '0; bus.count_i = '0;
    bus.key_sel_i = '0; bus.abort_i = 0; bus.ready_i = 0;
    bus2.wr_en_i = 0; bus2.wr_key_i = 0; bus2.wr_addr_i = '0; bus2.wr_text_i = '0;
    bus2.wr_keyd_i = '0; bus2.start_i = 0; bus2.base_addr_i = '0; bus2.count_i = '0;
    bus2.key_sel_i = '0; bus2.abort_i = 0; bus2.ready_i = 0;
  endtask

  task automatic wr(logic is_key, logic [3:0] a, logic [127:0] d);
    bus.wr_en_i = 1; bus.wr_key_i = is_key; bus.wr_addr_i = a;
    bus.wr_text_i = d; bus.wr_keyd_i = d;
    @(negedge clk);
    bus.wr_en_i = 0;
  endtask

  task automatic start1(logic [3:0] b, logic [4:0] c, logic ks, logic rd);
    bus.start_i = 1; bus.base_addr_i = b; bus.count_i = c; bus.key_sel_i = ks;
    bus.ready_i = rd;
    @(negedge clk);
    bus.start_i = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst valid", bus.valid_o, 0);
    check("rst busy", bus.busy_o, 0);
    check("rst done", bus.done_o, 0);
    check("rst last", bus.last_o, 0);
    check("rst pc", bus.pc_o, 0);
    check("rst text", bus.plaintext_q, 0);
    check("rst key", bus.key_q, 0);
    check("rst err", bus.err_o, 0);
    check("rst drop", bus.wr_drop_o, 0);
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) wr(1'b0, 4'(i), tv(i));
    wr(1'b1, 4'd0, K0);
    wr(1'b1, 4'd1, K1);
    check("load drop", bus.wr_drop_o, 0);

    // st  base   cnt  ks rdy ab | val pc  last busy done text key
    vecs.push_back(mk(1, 4'd0, 5'd4, 1, 1, 0, 1, 4'd0, 0, 1, 0, tv(0), K1));
    vecs.push_back(mk(0, 4'd0, 5'd0, 0, 1, 0, 1, 4'd1, 0, 1, 0, tv(1), K1));
    vecs.push_back(mk(0, 4'd0, 5'd0, 0, 1, 0, 1, 4'd2, 0, 1, 0, tv(2), K1));
    vecs.push_back(mk(0, 4'd0, 5'd0, 0, 1, 0, 1, 4'd3, 1, 1, 0, tv(3), K1));
    vecs.push_back(mk(0, 4'd0, 5'd0, 0, 1, 0, 0, 4'd3, 0, 1, 1, tv(3), K1));
    vecs.push_back(mk(0, 4'd0, 5'd0, 0, 1, 0, 0, 4'd3, 0, 0, 0, tv(3), K1));
    // wrap 14,15,0,1; start while busy ignored
    vecs.push_back(mk(1, 4'd14, 5'd4, 1, 1, 0, 1, 4'd14, 0, 1, 0, tv(14), K1));
    vecs.push_back(mk(1, 4'd5, 5'd2, 0, 1, 0, 1, 4'd15, 0, 1, 0, tv(15), K1));
    vecs.push_back(mk(0, 4'd0, 5'd0, 0, 1, 0, 1, 4'd0, 0, 1, 0, tv(0), K1));
    vecs.push_back(mk(0, 4'd0, 5'd0, 0, 1, 0, 1, 4'd1, 1, 1, 0, tv(1), K1));
    vecs.push_back(mk(0, 4'd0, 5'd0, 0, 1, 0, 0, 4'd1, 0, 1, 1, tv(1), K1));
    vecs.push_back(mk(0, 4'd0, 5'd0, 0, 1, 0, 0, 4'd1, 0, 0, 0, tv(1), K1));
    // three stalled cycles
    vecs.push_back(mk(1, 4'd0, 5'd3, 1, 0, 0, 1, 4'd0, 0, 1, 0, tv(0), K1));
    vecs.push_back(mk(0, 4'd0, 5'd0, 0, 0, 0, 1, 4'd0, 0, 1, 0, tv(0), K1));
    vecs.push_back(mk(0, 4'd0, 5'd0, 0, 0, 0, 1, 4'd0, 0, 1, 0, tv(0), K1));
    vecs.push_back(mk(0, 4'd0, 5'd0, 0, 0, 0, 1, 4'd0, 0, 1, 0, tv(0), K1));
    vecs.push_back(mk(0, 4'd0, 5'd0, 0, 1, 0, 1, 4'd1, 0, 1, 0, tv(1), K1));
    vecs.push_back(mk(0, 4'd0, 5'd0, 0, 1, 0, 1, 4'd2, 1, 1, 0, tv(2), K1));
    vecs.push_back(mk(0, 4'd0, 5'd0, 0, 1, 0, 0, 4'd2, 0, 1, 1, tv(2), K1));
    vecs.push_back(mk(0, 4'd0, 5'd0, 0, 1, 0, 0, 4'd2, 0, 0, 0, tv(2), K1));
    // count 0
    vecs.push_back(mk(1, 4'd0, 5'd0, 1, 1, 0, 0, 4'd2, 0, 1, 1, tv(2), K1));
    vecs.push_back(mk(0, 4'd0, 5'd0, 0, 1, 0, 0, 4'd2, 0, 0, 0, tv(2), K1));
    // abort beats handshake on beat 2
    vecs.push_back(mk(1, 4'd0, 5'd4, 0, 1, 0, 1, 4'd0, 0, 1, 0, tv(0), K0));
    vecs.push_back(mk(0, 4'd0, 5'd0, 0, 1, 0, 1, 4'd1, 0, 1, 0, tv(1), K0));
    vecs.push_back(mk(0, 4'd0, 5'd0, 0, 1, 1, 0, 4'd1, 0, 0, 0, tv(1), K0));
    vecs.push_back(mk(0, 4'd0, 5'd0, 0, 1, 0, 0, 4'd1, 0, 0, 0, tv(1), K0));

    foreach (vecs[i]) begin
      bus.start_i = vecs[i].start; bus.base_addr_i = vecs[i].base;
      bus.count_i = vecs[i].cnt;   bus.key_sel_i = vecs[i].ksel;
      bus.ready_i = vecs[i].ready; bus.abort_i = vecs[i].abort;
      @(negedge clk);
      check($sformatf("vec%0d valid", i), bus.valid_o, vecs[i].valid);
      check($sformatf("vec%0d pc", i), bus.pc_o, vecs[i].pc);
      check($sformatf("vec%0d last", i), bus.last_o, vecs[i].last);
      check($sformatf("vec%0d busy", i), bus.busy_o, vecs[i].busy);
      check($sformatf("vec%0d done", i), bus.done_o, vecs[i].done);
      check($sformatf("vec%0d text", i), bus.plaintext_q, vecs[i].text);
      check($sformatf("vec%0d key", i), bus.key_q, vecs[i].key);
      check($sformatf("vec%0d err", i), bus.err_o, 0);
    end
    idle_inputs();

    // Write while streaming is dropped
    start1(4'd0, 5'd3, 1'b1, 1'b0);
    check("busy stall", bus.busy_o, 1);
    wr(1'b0, 4'd2, 128'hDEAD);
    check("drop busy", bus.wr_drop_o, 1);
    @(negedge clk);
    check("drop pulse end", bus.wr_drop_o, 0);
    bus.abort_i = 1;
    @(negedge clk);
    bus.abort_i = 0;
    check("abort valid", bus.valid_o, 0);
    start1(4'd2, 5'd1, 1'b1, 1'b1);
    check("mem unchanged", bus.plaintext_q, tv(2));
    check("single last", bus.last_o, 1);
    @(negedge clk);
    check("single done", bus.done_o, 1);
    @(negedge clk);

    // Write and start on the same edge
    bus.wr_en_i = 1; bus.wr_key_i = 0; bus.wr_addr_i = 4'd5; bus.wr_text_i = AA;
    start1(4'd5, 5'd1, 1'b1, 1'b1);
    bus.wr_en_i = 0;
    check("simul old", bus.plaintext_q, tv(5));
    check("simul drop", bus.wr_drop_o, 0);
    repeat (2) @(negedge clk);
    start1(4'd5, 5'd1, 1'b1, 1'b1);
    check("simul new", bus.plaintext_q, AA);
    repeat (2) @(negedge clk);

    // Reset mid-stream
    start1(4'd0, 5'd4, 1'b1, 1'b1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("mid rst valid", bus.valid_o, 0);
    check("mid rst busy", bus.busy_o, 0);
    check("mid rst pc", bus.pc_o, 0);
    check("mid rst text", bus.plaintext_q, 0);
    check("mid rst key", bus.key_q, 0);
    @(negedge clk);
    check("mid rst no done", bus.done_o, 0);
    start1(4'd0, 5'd1, 1'b1, 1'b1);
    check("mem kept", bus.plaintext_q, tv(0));
    check("key kept", bus.key_q, K1);
    repeat (2) @(negedge clk);
    idle_inputs();

    // One key slot, 12 entries
    bus2.start_i = 1; bus2.key_sel_i = 1'b1; bus2.base_addr_i = 4'd0; bus2.count_i = 5'd1;
    @(negedge clk);
    bus2.start_i = 0;
    check("err ksel", bus2.err_o, 1);
    check("err busy", bus2.busy_o, 0);
    @(negedge clk);
    check("err pulse end", bus2.err_o, 0);
    bus2.start_i = 1; bus2.key_sel_i = 1'b0; bus2.base_addr_i = 4'd13;
    @(negedge clk);
    bus2.start_i = 0;
    check("err base", bus2.err_o, 1);
    check("err base valid", bus2.valid_o, 0);
    bus2.wr_en_i = 1; bus2.wr_key_i = 0; bus2.wr_addr_i = 4'd12;
    @(negedge clk);
    check("drop addr", bus2.wr_drop_o, 1);
    bus2.wr_key_i = 1; bus2.wr_addr_i = 4'd1; bus2.wr_keyd_i = K1;
    @(negedge clk);
    check("drop slot", bus2.wr_drop_o, 1);
    bus2.wr_addr_i = 4'd0; bus2.wr_keyd_i = K0;
    @(negedge clk);
    check("key ok", bus2.wr_drop_o, 0);
    bus2.wr_key_i = 0; bus2.wr_addr_i = 4'd11; bus2.wr_text_i = 128'h11;
    @(negedge clk);
    bus2.wr_addr_i = 4'd0; bus2.wr_text_i = 128'h22;
    @(negedge clk);
    bus2.wr_en_i = 0;
    bus2.start_i = 1; bus2.base_addr_i = 4'd11; bus2.count_i = 5'd2; bus2.ready_i = 1;
    @(negedge clk);
    bus2.start_i = 0;
    check("wrap12 pc0", bus2.pc_o, 11);
    check("wrap12 text0", bus2.plaintext_q, 128'h11);
    check("wrap12 key", bus2.key_q, K0);
    @(negedge clk);
    check("wrap12 pc1", bus2.pc_o, 0);
    check("wrap12 text1", bus2.plaintext_q, 128'h22);
    check("wrap12 last", bus2.last_o, 1);
    @(negedge clk);
    check("wrap12 done", bus2.done_o, 1);
    idle_inputs();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/plaintext_key_stream_memory.md
Name: plaintext_key_stream_memory

Overview:
- Parametrised, clocked successor to the combinational plaintext/key ROM.
- Holds MEMORY_SIZE plaintext blocks and KEY_SLOTS keys, both loadable at run time through a write port.
- On command, streams a run of plaintext blocks plus one selected key to the AES core over a valid/ready handshake, with address wrap-around and completion signalling.
- Sits between the testbench/host loader and the AES encryption datapath.

Parameters:
TEXT_WIDTH, 128, plaintext block width in bits
KEY_WIDTH, 128, key width in bits
ADDR_WIDTH, 4, plaintext address width
MEMORY_SIZE, 16, plaintext entries; must be <= 2**ADDR_WIDTH
KEY_SLOTS, 2, number of key entries
KSEL_WIDTH, 1, key slot index width; must satisfy 2**KSEL_WIDTH >= KEY_SLOTS

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
wr_en_i  input  1  write strobe
wr_key_i  input  1  write target: 0 = plaintext array, 1 = key array
wr_addr_i  input  ADDR_WIDTH  write address (key slot uses the low KSEL_WIDTH bits)
wr_text_i  input  TEXT_WIDTH  plaintext write data
wr_keyd_i  input  KEY_WIDTH  key write data
wr_drop_o  output  1  one-cycle pulse: a write was ignored
start_i  input  1  begin stream (sampled in IDLE only)
base_addr_i  input  ADDR_WIDTH  first plaintext address
count_i  input  ADDR_WIDTH+1  number of blocks to stream
key_sel_i  input  KSEL_WIDTH  key slot for this stream
abort_i  input  1  cancel the active stream
plaintext_q  output  TEXT_WIDTH  current plaintext beat
key_q  output  KEY_WIDTH  key for the stream, constant while busy
pc_o  output  ADDR_WIDTH  address of the current beat
valid_o  output  1  beat valid
ready_i  input  1  consumer accepts the beat
last_o  output  1  current beat is the final beat
busy_o  output  1  stream in progress
done_o  output  1  one-cycle pulse: stream completed
err_o  output  1  one-cycle pulse: start rejected

Behaviour:
- Reset: every output is 0 and the FSM goes to IDLE. Array contents are not cleared. Reset mid-stream drops the stream with no done_o pulse.
- FSM states: IDLE, STREAM, DONE.
- Writes:
  - A write is accepted only in IDLE. The selected array entry updates at the clock edge.
  - A plaintext write with wr_addr_i >= MEMORY_SIZE, or a key write with slot >= KEY_SLOTS, is ignored and pulses wr_drop_o.
  - A write in STREAM or DONE is ignored and pulses wr_drop_o.
- Start, sampled in IDLE:
  - key_sel_i >= KEY_SLOTS or base_addr_i >= MEMORY_SIZE: err_o pulses and the FSM stays in IDLE.
  - count_i == 0: go to DONE. No beats are produced; done_o pulses next cycle.
  - Otherwise, at the same edge: plaintext_q <= MEMORY[base], key_q <= KEY[key_sel], pc_o <= base, remaining <= count_i, and the FSM goes to STREAM. valid_o is 1 from the next cycle, so first-beat latency is 1 cycle.
  - If wr_en_i and start_i are both high in IDLE, the write takes effect and the start reads pre-write contents.
- STREAM:
  - valid_o = 1, busy_o = 1, last_o = (remaining == 1).
  - While valid_o && !ready_i, plaintext_q, pc_o and last_o hold stable.
  - On a handshake that is not the last beat: pc <= (pc == MEMORY_SIZE-1) ? 0 : pc+1, plaintext_q <= MEMORY[next pc], remaining decrements. Throughput is one beat per cycle.
  - On a handshake on the last beat: go to DONE and drop valid_o in the next cycle.
  - count_i > MEMORY_SIZE is legal; addresses wrap and the stream repeats.
  - abort_i: go to IDLE next cycle with valid_o = 0 and no done_o. abort_i takes priority over a simultaneous handshake.
  - start_i while busy is ignored, with no err_o.
- DONE: lasts one cycle with done_o = 1, busy_o = 1, valid_o = 0, then goes to IDLE.
- busy_o = 1 in STREAM and DONE.
- key_q holds its last value in IDLE.

Test Plan:
- Load MEMORY[0..3] = 0x00..01..0x00..04 and KEY[1] = 0x2b7e1516..., then start base=0, count=4, key_sel=1 with ready_i tied 1 -> valid_o high on 4 consecutive cycles starting 1 cycle after start; pc_o = 0,1,2,3; last_o on pc 3; done_o 1 cycle later; key_q = KEY[1] throughout.
- Start base=14, count=4 (MEMORY_SIZE=16) -> pc_o sequence 14,15,0,1.
- Start base=0, count=3, ready_i low for 3 cycles then high -> plaintext_q and pc_o held at 0 during the stall; all 3 beats delivered, none lost or duplicated.
- Start count=0 -> no valid_o; done_o pulses 1 cycle after start. Start key_sel=1 with KEY_SLOTS=1 -> err_o pulse; busy_o stays 0.
- During a stream: wr_en_i -> wr_drop_o pulse and memory unchanged. abort_i on beat 2 -> valid_o 0 next cycle, no done_o. rst asserted mid-stream -> all outputs 0 the cycle after.
- Simultaneous write to MEMORY[5] = 0xAA.. and start base=5 in IDLE -> first beat carries the old contents; a second stream returns 0xAA...
